// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_pkg
// Brief    : Shared state encoding and sizing helper for the bit-serial adder.
// Revision : 1.0  initial release
// ============================================================================
package serial_adder_pkg;

    // Controller states of the serial adder
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sadd_state_t;

    // Bit-counter width needed to index WIDTH operand bits
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/fulladder.sv
`default_nettype none
// ============================================================================
// Module   : fulladder
// Brief    : One-bit full adder stage (a + b + cin -> s, cout).
// Revision : 1.0  initial release
// ============================================================================
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum and majority carry of the three input bits
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule : fulladder
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Brief    : Multi-cycle bit-serial WIDTH-bit adder with start/done handshake.
//            Feeds one operand bit pair per clock (LSB first) through a single
//            full-adder stage, keeping the carry in a flop between cycles.
// Revision : 1.0  initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    sadd_state_t       r_state;
    logic [WIDTH-1:0]  r_a_sh;
    logic [WIDTH-1:0]  r_b_sh;
    logic [WIDTH-1:0]  r_sum_sh;
    logic              r_carry;
    logic              r_carry_msb;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ready;
    logic              r_busy;
    logic              r_done;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;

    logic              w_s;
    logic              w_cout;

    // Single shared one-bit adder stage, fed from the LSBs of the shifters
    fulladder u_fa (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    // Controller, operand/sum shifters and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_sum_sh    <= '0;
            r_carry     <= 1'b0;
            r_carry_msb <= 1'b0;
            r_cnt       <= '0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_sum_sh <= {w_s, r_sum_sh[WIDTH-1:1]};
                    r_carry  <= w_cout;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        // MSB pair is in the adder now: r_carry is the
                        // carry into the MSB, w_cout the final carry out.
                        r_carry_msb <= r_carry;
                        r_sum       <= {w_s, r_sum_sh[WIDTH-1:1]};
                        r_cout      <= w_cout;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready    = r_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign sum      = r_sum;
    assign cout     = r_cout;
    // Both terms only change together on the RUN->DONE edge, so this holds
    // steady alongside sum/cout.
    assign overflow = r_carry_msb ^ r_cout;

endmodule : serial_adder
`default_nettype wire
